// File: rtl/t05_sram_burst_port.sv
// Multi-client SRAM burst engine: round-robin arbitration of NCLIENT requesters
// onto one wishbone-style master port, sequencing read, write and zero-fill bursts.
module t05_sram_burst_port #(
   parameter int          NCLIENT   = 4,
   parameter int          MAX_WORDS = 4,
   parameter int          AW        = 12,
   parameter int          LW        = 12,
   parameter logic [31:0] BASE_ADDR = 32'h3300_0000,
   parameter int          DEPTH     = 4096
) (
   input  logic                            clk,
   input  logic                            nrst,
   input  logic [NCLIENT-1:0]              req,
   input  logic [2*NCLIENT-1:0]            op,
   input  logic [NCLIENT*AW-1:0]           word_addr,
   input  logic [NCLIENT*LW-1:0]           len,
   input  logic [NCLIENT*MAX_WORDS*32-1:0] wdata,
   output logic [NCLIENT-1:0]              grant,
   output logic [NCLIENT-1:0]              done,
   output logic [NCLIENT-1:0]              err,
   output logic [MAX_WORDS*32-1:0]         rdata,
   output logic                            active,
   output logic                            wr_en,
   output logic                            r_en,
   output logic [3:0]                      select,
   output logic [31:0]                     addr,
   output logic [31:0]                     data_i,
   input  logic                            busy_o,
   input  logic [31:0]                     data_o,
   output logic [2:0]                      state_dbg
);

   localparam int IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
   localparam int SW = ((AW > LW) ? AW : LW) + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t                  state;
   logic [IW-1:0]           ptr;
   logic [IW-1:0]           owner;
   logic [1:0]              cur_op;
   logic [AW-1:0]           cur_addr;
   logic [LW-1:0]           cur_len;
   logic [LW-1:0]           k;
   logic [MAX_WORDS*32-1:0] cur_wdata;
   logic                    busy_last;

   logic [1:0]              op_a   [NCLIENT];
   logic [AW-1:0]           addr_a [NCLIENT];
   logic [LW-1:0]           len_a  [NCLIENT];
   logic [MAX_WORDS*32-1:0] wd_a   [NCLIENT];

   for (genvar g = 0; g < NCLIENT; g++) begin : g_unpack
      assign op_a[g]   = op[2*g +: 2];
      assign addr_a[g] = word_addr[AW*g +: AW];
      assign len_a[g]  = len[LW*g +: LW];
      assign wd_a[g]   = wdata[MAX_WORDS*32*g +: MAX_WORDS*32];
   end

   // Handshake: a client raises req (level) with op/word_addr/len/wdata valid and
   // keeps it up until it sees its done or err pulse; grant is the ready/ownership
   // indication and stays high for the whole transfer. Fields are latched at grant.
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] cand;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = ptr;
      cand       = ptr;
      for (int i = 0; i < NCLIENT; i++) begin
         cand = IW'((int'(ptr) + i) % NCLIENT);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Range check is done one bit wider than the operands so an overrun cannot wrap.
   logic [SW-1:0] end_word;
   logic          reject;
   assign end_word = SW'(cur_addr) + SW'(cur_len);
   assign reject   = (cur_op == 2'b11) ||
                     ((cur_op != 2'b10) && (32'(cur_len) >= 32'(MAX_WORDS))) ||
                     (32'(end_word) >= 32'(DEPTH));

   logic [31:0]   bus_word;
   logic [IW-1:0] next_ptr;
   assign bus_word = 32'(cur_addr) + 32'(k);
   assign next_ptr = (int'(owner) == NCLIENT - 1) ? '0 : owner + 1'b1;

   function automatic logic [31:0] pick_word(input logic [MAX_WORDS*32-1:0] w,
                                             input logic [LW-1:0] idx);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < MAX_WORDS; j++) begin
         if (idx == LW'(j)) r = w[(MAX_WORDS-1-j)*32 +: 32];
      end
      return r;
   endfunction

   assign select    = 4'hF;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         owner     <= '0;
         cur_op    <= '0;
         cur_addr  <= '0;
         cur_len   <= '0;
         cur_wdata <= '0;
         k         <= '0;
         busy_last <= 1'b0;
         grant     <= '0;
         done      <= '0;
         err       <= '0;
         rdata     <= '0;
         active    <= 1'b0;
         wr_en     <= 1'b0;
         r_en      <= 1'b0;
         addr      <= '0;
         data_i    <= '0;
      end else begin
         busy_last <= busy_o;
         wr_en     <= 1'b0;
         r_en      <= 1'b0;
         done      <= '0;
         err       <= '0;
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  owner     <= pick_idx;
                  grant     <= NCLIENT'(1) << pick_idx;
                  active    <= 1'b1;
                  cur_op    <= op_a[pick_idx];
                  cur_addr  <= addr_a[pick_idx];
                  cur_len   <= len_a[pick_idx];
                  cur_wdata <= wd_a[pick_idx];
                  state     <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (reject) begin
                  err[owner] <= 1'b1;
                  grant      <= '0;
                  active     <= 1'b0;
                  ptr        <= next_ptr;
                  state      <= S_FINISH;
               end else begin
                  k <= '0;
                  if (cur_op == 2'b00) rdata <= '0;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!busy_o) begin
                  addr   <= BASE_ADDR + {bus_word[29:0], 2'b00};
                  data_i <= (cur_op == 2'b01) ? pick_word(cur_wdata, k) : 32'h0;
                  r_en   <= (cur_op == 2'b00);
                  wr_en  <= (cur_op != 2'b00);
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (busy_last && !busy_o) begin
                  if (cur_op == 2'b00) begin
                     for (int j = 0; j < MAX_WORDS; j++) begin
                        if (k == LW'(j)) rdata[(MAX_WORDS-1-j)*32 +: 32] <= data_o;
                     end
                  end
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (k == cur_len) begin
                  done[owner] <= 1'b1;
                  grant       <= '0;
                  active      <= 1'b0;
                  ptr         <= next_ptr;
                  state       <= S_FINISH;
               end else begin
                  k     <= k + 1'b1;
                  state <= S_ISSUE;
               end
            end
            // Retire cycle: done/err is visible here so the client can drop req
            // before arbitration looks at it again.
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t05_sram_burst_port.sv
// Bench for t05_sram_burst_port: SRAM bus model with scoreboard, vector table,
// randomized requests, reset mid-burst and round-robin ordering.
module tb_t05_sram_burst_port;

   localparam int          NC    = 4;
   localparam int          MW    = 4;
   localparam int          AW    = 12;
   localparam int          LW    = 12;
   localparam logic [31:0] BASE  = 32'h3300_0000;
   localparam int          DEPTH = 4096;

   logic                 clk;
   logic                 nrst;
   logic [NC-1:0]        req;
   logic [2*NC-1:0]      op;
   logic [NC*AW-1:0]     word_addr;
   logic [NC*LW-1:0]     len;
   logic [NC*MW*32-1:0]  wdata;
   logic [NC-1:0]        grant;
   logic [NC-1:0]        done;
   logic [NC-1:0]        err;
   logic [MW*32-1:0]     rdata;
   logic                 active;
   logic                 wr_en;
   logic                 r_en;
   logic [3:0]           select;
   logic [31:0]          addr;
   logic [31:0]          data_i;
   logic                 busy_o;
   logic [31:0]          data_o;
   logic [2:0]           state_dbg;

   t05_sram_burst_port #(
      .NCLIENT(NC), .MAX_WORDS(MW), .AW(AW), .LW(LW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .nrst(nrst), .req(req), .op(op), .word_addr(word_addr), .len(len),
      .wdata(wdata), .grant(grant), .done(done), .err(err), .rdata(rdata),
      .active(active), .wr_en(wr_en), .r_en(r_en), .select(select), .addr(addr),
      .data_i(data_i), .busy_o(busy_o), .data_o(data_o), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   logic [31:0]  mem [DEPTH];
   logic [64:0]  exp_q[$];
   logic [127:0] exp_rdata;
   bit           sb_en;
   bit           blip_en;
   int           strobe_cnt;
   int           zero_data_cnt;
   logic [31:0]  last_addr;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SRAM bus model + scoreboard of expected bus operations {we, addr, data}
   initial begin
      int          cnt;
      int          w;
      logic [31:0] pend;
      logic [64:0] e;
      cnt = 0; busy_o = 1'b0; data_o = '0; pend = '0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            cnt = 0;
            busy_o = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               busy_o = 1'b0;
               data_o = pend;
            end
         end else if (wr_en || r_en) begin
            strobe_cnt++;
            last_addr = addr;
            if (data_i == 32'h0) zero_data_cnt++;
            check("strobe_exclusive", 128'(wr_en & r_en), 128'(0));
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_strobe: got addr %0h, required no strobe", addr);
               end else begin
                  e = exp_q.pop_front();
                  check("bus_op", 128'({wr_en, addr, data_i}), 128'(e));
               end
            end
            w = int'((addr - BASE) >> 2);
            if (w >= 0 && w < DEPTH) begin
               if (wr_en) mem[w] = data_i;
               else pend = mem[w];
            end
            busy_o = 1'b1;
            data_o = $urandom;
            cnt = $urandom_range(1, 3);
         end else if (blip_en && $urandom_range(0, 7) == 0) begin
            busy_o = 1'b1;
            cnt = 1;
         end
      end
   end

   function automatic bit model_err(input logic [1:0] o, input logic [11:0] wa, input logic [11:0] ln);
      return (o == 2'b11) || (o != 2'b10 && int'(ln) >= MW) || (int'(wa) + int'(ln) >= DEPTH);
   endfunction

   // driver: one client request, run to done/err, then check outcome
   task automatic do_req(input int c, input logic [1:0] o, input logic [11:0] wa,
                         input logic [11:0] ln, output bit got_done, output bit got_err);
      logic [31:0] w [MW];
      bit          e;
      int          budget;
      int          gcyc;
      int          extra;
      int          multi;
      e = model_err(o, wa, ln);
      for (int i = 0; i < MW; i++) w[i] = $urandom;
      if (!e) begin
         for (int i = 0; i <= int'(ln); i++)
            exp_q.push_back({o != 2'b00, BASE + 32'((int'(wa) + i) * 4),
                             (o == 2'b01 && i < MW) ? w[i] : 32'h0});
         if (o == 2'b00) begin
            exp_rdata = '0;
            for (int i = 0; i <= int'(ln); i++)
               exp_rdata[(MW-1-i)*32 +: 32] = mem[int'(wa) + i];
         end
      end
      op[c*2 +: 2] = o;
      word_addr[c*AW +: AW] = wa;
      len[c*LW +: LW] = ln;
      for (int i = 0; i < MW; i++) wdata[c*MW*32 + (MW-1-i)*32 +: 32] = w[i];
      req[c] = 1'b1;
      got_done = 0; got_err = 0; gcyc = -1; multi = 0;
      budget = (int'(ln) + 1) * 10 + 40;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         if (gcyc < 0 && grant[c]) gcyc = cyc;
         if ($countones(grant) > 1) multi++;
         if (done[c]) got_done = 1;
         if (err[c]) got_err = 1;
         if (got_done || got_err) break;
      end
      req[c] = 1'b0;
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done != '0 || err != '0) extra++;
      end
      check("done_pulse", 128'(got_done), 128'(!e));
      check("err_pulse", 128'(got_err), 128'(e));
      check("extra_pulse", 128'(extra), 128'(0));
      check("grant_latency", 128'(gcyc), 128'(1));
      check("grant_onehot", 128'(multi), 128'(0));
      check("bus_ops_left", 128'(exp_q.size()), 128'(0));
      check("rdata", rdata, exp_rdata);
      check("idle_active", 128'(active), 128'(0));
      check("idle_grant", 128'(grant), 128'(0));
      exp_q.delete();
   endtask

   typedef struct {
      int           client;
      logic [1:0]   op;
      logic [11:0]  wa;
      logic [11:0]  ln;
      bit           exp_err;
      int           exp_strobes;
      logic [31:0]  exp_last;
      bit           chk_rd;
      logic [127:0] rd_val;
   } vec_t;

   vec_t tbl [11];

   initial begin
      bit gd, ge;
      int rr_order [8];
      int rr_exp [4];
      int rr_n, rr_multi, done0_cnt, tries;
      bit reassert0;
      logic [NC-1:0] prev_grant;

      total = 0; bad = 0;
      nrst = 1'b0; req = '0; op = '0; word_addr = '0; len = '0; wdata = '0;
      sb_en = 1; blip_en = 0; exp_rdata = '0; strobe_cnt = 0; zero_data_cnt = 0; last_addr = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'ha0 + 32'(i);

      tbl[0]  = '{2, 2'b00, 12'h010, 12'd3,    0, 4,    32'h3300004C, 1, {32'ha0, 32'ha1, 32'ha2, 32'ha3}};
      tbl[1]  = '{1, 2'b01, 12'hFFE, 12'd1,    0, 2,    32'h33003FFC, 0, 128'h0};
      tbl[2]  = '{1, 2'b01, 12'hFFF, 12'd1,    1, 0,    32'h0,        0, 128'h0};
      tbl[3]  = '{0, 2'b00, 12'h100, 12'd4,    1, 0,    32'h0,        1, {32'ha0, 32'ha1, 32'ha2, 32'ha3}};
      tbl[4]  = '{3, 2'b11, 12'h020, 12'd0,    1, 0,    32'h0,        0, 128'h0};
      tbl[5]  = '{0, 2'b10, 12'h000, 12'd2047, 0, 2048, 32'h33001FFC, 0, 128'h0};
      tbl[6]  = '{1, 2'b00, 12'hFFC, 12'd3,    0, 4,    32'h33003FFC, 0, 128'h0};
      tbl[7]  = '{3, 2'b01, 12'h000, 12'd3,    0, 4,    32'h3300000C, 0, 128'h0};
      tbl[8]  = '{2, 2'b10, 12'hFFF, 12'd0,    0, 1,    32'h33003FFC, 0, 128'h0};
      tbl[9]  = '{0, 2'b10, 12'hF01, 12'hFF,   1, 0,    32'h0,        0, 128'h0};
      tbl[10] = '{2, 2'b00, 12'h000, 12'd0,    0, 1,    32'h33000000, 0, 128'h0};

      repeat (3) @(negedge clk);
      check("rst_grant", 128'(grant), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_rdata", rdata, 128'(0));
      check("rst_strobes", 128'({wr_en, r_en, active}), 128'(0));
      check("rst_addr_data", 128'({addr, data_i}), 128'(0));
      check("rst_select", 128'(select), 128'(4'hF));
      nrst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 11; v++) begin
         strobe_cnt = 0; zero_data_cnt = 0;
         do_req(tbl[v].client, tbl[v].op, tbl[v].wa, tbl[v].ln, gd, ge);
         check($sformatf("vec%0d_err", v), 128'(ge), 128'(tbl[v].exp_err));
         check($sformatf("vec%0d_strobes", v), 128'(strobe_cnt), 128'(tbl[v].exp_strobes));
         if (tbl[v].exp_strobes > 0)
            check($sformatf("vec%0d_last_addr", v), 128'(last_addr), 128'(tbl[v].exp_last));
         if (tbl[v].op == 2'b10 && !tbl[v].exp_err)
            check($sformatf("vec%0d_fill_zero", v), 128'(zero_data_cnt), 128'(tbl[v].exp_strobes));
         if (tbl[v].chk_rd)
            check($sformatf("vec%0d_rdata_const", v), rdata, tbl[v].rd_val);
      end

      blip_en = 1;
      for (int t = 0; t < 40; t++) begin
         int r;
         logic [1:0] o;
         logic [11:0] wa, ln;
         r = $urandom_range(0, 9);
         o = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         ln = (o == 2'b10) ? 12'($urandom_range(0, 20)) : 12'($urandom_range(0, 5));
         wa = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(4080, 4095));
         do_req($urandom_range(0, NC - 1), o, wa, ln, gd, ge);
      end
      blip_en = 0;

      do_req(1, 2'b00, 12'h200, 12'd3, gd, ge);

      // reset in the middle of a fill burst
      sb_en = 0;
      op[1:0] = 2'b10; word_addr[AW-1:0] = 12'h300; len[LW-1:0] = 12'd200;
      strobe_cnt = 0;
      req[0] = 1'b1;
      tries = 0;
      while (strobe_cnt < 5 && tries < 200) begin
         @(negedge clk);
         tries++;
      end
      check("midburst_reached", 128'(strobe_cnt >= 5), 128'(1));
      check("midburst_active", 128'(active), 128'(1));
      @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      check("mid_rst_grant", 128'(grant), 128'(0));
      check("mid_rst_active", 128'(active), 128'(0));
      check("mid_rst_strobes", 128'({wr_en, r_en}), 128'(0));
      check("mid_rst_pulses", 128'({done, err}), 128'(0));
      check("mid_rst_rdata", rdata, 128'(0));
      check("mid_rst_addr_data", 128'({addr, data_i}), 128'(0));
      check("mid_rst_select", 128'(select), 128'(4'hF));
      req = '0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_rdata = '0;
      nrst = 1'b1;
      @(negedge clk);
      check("post_rst_no_done", 128'(done), 128'(0));

      // round-robin: clients 0,1,3 request together, 0 re-requests after its done
      rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 3; rr_exp[3] = 0;
      for (int c = 0; c < NC; c++) begin
         op[c*2 +: 2] = 2'b00; word_addr[c*AW +: AW] = 12'(c * 8); len[c*LW +: LW] = 12'd0;
      end
      rr_n = 0; rr_multi = 0; done0_cnt = 0; reassert0 = 0; prev_grant = '0;
      req = 4'b1011;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if ($countones(grant) > 1) rr_multi++;
         if (grant != '0 && grant != prev_grant && rr_n < 8) begin
            for (int c = 0; c < NC; c++) if (grant[c]) rr_order[rr_n] = c;
            rr_n++;
         end
         prev_grant = grant;
         if (reassert0) begin
            req[0] = 1'b1;
            reassert0 = 0;
         end
         for (int c = 0; c < NC; c++) begin
            if (done[c]) begin
               req[c] = 1'b0;
               if (c == 0) begin
                  if (done0_cnt == 0) reassert0 = 1;
                  done0_cnt++;
               end
            end
         end
         if (done0_cnt == 2 && req == '0) break;
      end
      repeat (3) @(negedge clk);
      check("rr_grant_count", 128'(rr_n), 128'(4));
      check("rr_onehot", 128'(rr_multi), 128'(0));
      for (int i = 0; i < 4; i++)
         check($sformatf("rr_order%0d", i), 128'(rr_order[i]), 128'(rr_exp[i]));
      sb_en = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

endmodule
